// File: rtl/relu_node_queue_param.sv
// Snapshot queue for one layer of ReLU node values, drained one node per cycle
// over valid/ready, optionally skipping zero activations.
module relu_node_queue_param #(
  parameter int NODE_COUNT  = 8,
  parameter int VALUE_WIDTH = 4,
  parameter bit SKIP_ZERO   = 1'b1,
  localparam int IW = $clog2(NODE_COUNT),
  localparam int CW = $clog2(NODE_COUNT + 1)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              load,
  input  logic [NODE_COUNT*VALUE_WIDTH-1:0] node_values_in,
  input  logic                              flush,
  output logic                              load_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IW-1:0]                     index_out,
  output logic [VALUE_WIDTH-1:0]            value_out,
  output logic                              last_out,
  output logic                              queue_empty,
  output logic [CW-1:0]                     pending_count
);

  logic [NODE_COUNT*VALUE_WIDTH-1:0] snapshot;
  logic [NODE_COUNT-1:0]             mask;
  logic [NODE_COUNT-1:0]             load_mask;

  // Node 0 lives in the most significant slot.
  function automatic logic [VALUE_WIDTH-1:0] node_at(
    input logic [NODE_COUNT*VALUE_WIDTH-1:0] vec,
    input int                                i
  );
    return vec[(NODE_COUNT-i)*VALUE_WIDTH-1 -: VALUE_WIDTH];
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [NODE_COUNT-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NODE_COUNT; i++) c = c + CW'(m[i]);
    return c;
  endfunction

  always_comb begin
    load_mask = '0;
    for (int i = 0; i < NODE_COUNT; i++)
      load_mask[i] = SKIP_ZERO ? (node_at(node_values_in, i) != '0) : 1'b1;
  end

  // Descending scan so the lowest pending index wins.
  always_comb begin
    index_out = '0;
    value_out = '0;
    for (int i = NODE_COUNT - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index_out = IW'(i);
        value_out = node_at(snapshot, i);
      end
    end
  end

  assign out_valid   = |mask;
  assign queue_empty = ~out_valid;
  assign load_ready  = queue_empty;
  assign last_out    = out_valid && (pending_count == CW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot      <= '0;
      mask          <= '0;
      pending_count <= '0;
    end else if (flush) begin
      mask          <= '0;
      pending_count <= '0;
    end else if (load && load_ready) begin
      snapshot      <= node_values_in;
      mask          <= load_mask;
      pending_count <= popcount(load_mask);
    end else if (out_valid && out_ready) begin
      // Clearing the lowest set bit retires exactly the presented entry.
      mask          <= mask & (mask - NODE_COUNT'(1));
      pending_count <= pending_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_relu_node_queue_param.sv
// Bench for relu_node_queue_param: zero-skip and keep-all instances driven in
// parallel and compared every cycle against queue-based models.
module tb_relu_node_queue_param;

  localparam int NC = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [NC*VW-1:0] vals = '0;

  logic       lr1, ov1, last1, emp1;
  logic [2:0] idx1;
  logic [3:0] val1, cnt1;
  logic       lr0, ov0, last0, emp0;
  logic [2:0] idx0;
  logic [3:0] val0, cnt0;

  int tests = 0;
  int fails = 0;
  bit comparing = 1'b1;

  typedef struct { int idx; int val; } ent_t;
  ent_t q1[$];
  ent_t q0[$];

  relu_node_queue_param #(.NODE_COUNT(NC), .VALUE_WIDTH(VW), .SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .node_values_in(vals), .flush(flush),
    .load_ready(lr1), .out_valid(ov1), .out_ready(out_ready), .index_out(idx1),
    .value_out(val1), .last_out(last1), .queue_empty(emp1), .pending_count(cnt1));

  relu_node_queue_param #(.NODE_COUNT(NC), .VALUE_WIDTH(VW), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load(load), .node_values_in(vals), .flush(flush),
    .load_ready(lr0), .out_valid(ov0), .out_ready(out_ready), .index_out(idx0),
    .value_out(val0), .last_out(last0), .queue_empty(emp0), .pending_count(cnt0));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int node_val(input logic [NC*VW-1:0] v, input int i);
    return int'((v >> ((NC - 1 - i) * VW)) & 32'hF);
  endfunction

  // Reference model: a list of (index,value) entries in emission order.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        q1.delete();
        q0.delete();
      end else begin
        if (flush) q1.delete();
        else if (load && q1.size() == 0) begin
          for (int i = 0; i < NC; i++)
            if (node_val(vals, i) != 0) q1.push_back('{i, node_val(vals, i)});
        end else if (q1.size() > 0 && out_ready) void'(q1.pop_front());
        if (flush) q0.delete();
        else if (load && q0.size() == 0) begin
          for (int i = 0; i < NC; i++) q0.push_back('{i, node_val(vals, i)});
        end else if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (comparing) begin
        check("skip.out_valid", ov1, q1.size() > 0);
        check("skip.index", idx1, q1.size() > 0 ? q1[0].idx : 0);
        check("skip.value", val1, q1.size() > 0 ? q1[0].val : 0);
        check("skip.last", last1, q1.size() == 1);
        check("skip.empty", emp1, q1.size() == 0);
        check("skip.load_ready", lr1, q1.size() == 0);
        check("skip.count", cnt1, q1.size());
        check("keep.out_valid", ov0, q0.size() > 0);
        check("keep.index", idx0, q0.size() > 0 ? q0[0].idx : 0);
        check("keep.value", val0, q0.size() > 0 ? q0[0].val : 0);
        check("keep.last", last0, q0.size() == 1);
        check("keep.empty", emp0, q0.size() == 0);
        check("keep.load_ready", lr0, q0.size() == 0);
        check("keep.count", cnt0, q0.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [NC*VW-1:0] v);
    vals = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic flush_all();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    // Reset with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      vals = {$urandom, $urandom} ;
      load = 1'($urandom);
      out_ready = 1'($urandom);
      flush = 1'($urandom);
      tick();
    end
    reset_n = 1'b1;
    load = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("rst.load_ready", lr1, 1);
    check("rst.empty", emp1, 1);
    check("rst.out_valid", ov1, 0);
    check("rst.index", idx1, 0);
    check("rst.value", val1, 0);
    check("rst.count", cnt1, 0);

    // Full drain of a dense snapshot.
    tick();
    out_ready = 1'b1;
    do_load(32'h12345678);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drain.index", idx1, i);
      check("drain.value", val1, i + 1);
      check("drain.last", last1, i == 7);
      tick();
    end
    @(negedge clk);
    check("drain.empty_after", emp1, 1);

    // Sparse snapshot with back-pressure.
    flush_all();
    out_ready = 1'b0;
    do_load(32'h0A0000B0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp.count", cnt1, 2);
      check("bp.index", idx1, 1);
      check("bp.value", val1, 4'hA);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.release_index", idx1, 1);
    tick();
    @(negedge clk);
    check("bp.second_index", idx1, 6);
    check("bp.second_value", val1, 4'hB);
    check("bp.second_last", last1, 1);
    tick();
    @(negedge clk);
    check("bp.count_done", cnt1, 0);

    // All-zero snapshot in both modes.
    flush_all();
    out_ready = 1'b1;
    do_load(32'h00000000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("zero.skip_valid", ov1, 0);
      check("zero.skip_ready", lr1, 1);
      check("zero.keep_valid", ov0, 1);
      check("zero.keep_index", idx0, i);
      check("zero.keep_value", val0, 0);
      tick();
    end

    // Load while busy is ignored; flush discards a coincident transfer.
    flush_all();
    out_ready = 1'b1;
    do_load(32'h11111111);
    @(negedge clk);
    check("busy.first", idx1, 0);
    tick();
    @(negedge clk);
    check("busy.second", idx1, 1);
    vals = 32'h22222222;
    load = 1'b1;
    tick();
    load = 1'b0;
    @(negedge clk);
    check("busy.index_after", idx1, 2);
    check("busy.value_after", val1, 1);
    tick();
    @(negedge clk);
    check("busy.next_value", val1, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush.valid", ov1, 0);
    check("flush.count", cnt1, 0);
    check("flush.load_ready", lr1, 1);

    // Asynchronous reset between edges, mid-drain.
    do_load(32'h12345678);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("arst.pre_count", cnt1, 5);
    #1 reset_n = 1'b0;
    #1;
    check("arst.valid", ov1, 0);
    check("arst.empty", emp1, 1);
    check("arst.count", cnt1, 0);
    tick();
    reset_n = 1'b1;
    do_load(32'h9ABCDEF1);
    @(negedge clk);
    check("arst.fresh_index", idx1, 0);
    check("arst.fresh_value", val1, 9);
    for (int i = 0; i < 8; i++) tick();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [NC*VW-1:0] v;
      for (int n = 0; n < NC; n++)
        v[n*VW +: VW] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      vals = v;
      load = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      tick();
    end
    load = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    comparing = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/relu_node_queue_param.md
# relu_node_queue_param

Parametrised successor to the layer's ReLU output queue. It captures one layer's worth of ReLU node values in a single snapshot and serialises them one node per cycle to the downstream accumulator over a valid/ready handshake. In zero-skip mode it drops nodes whose activation is zero, so downstream sees only useful work. Unlike the previous queue it reports real emptiness, occupancy and last-entry status, and it supports flush and back-pressure.

## Interface
- NODE_COUNT, 8: nodes per snapshot; must be 2 or more.
- VALUE_WIDTH, 4: bits per node value (unsigned).
- SKIP_ZERO, 1: 1 = enqueue only nonzero values; 0 = enqueue every node.
- IW = $clog2(NODE_COUNT), CW = $clog2(NODE_COUNT+1): derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset. All state clears immediately on assertion. Deassertion is synchronous to clk.
- load  in  1  capture request for node_values_in; accepted only when load_ready=1.
- node_values_in  in  NODE_COUNT*VALUE_WIDTH  node i occupies bits [(NODE_COUNT-i)*VALUE_WIDTH-1 -: VALUE_WIDTH], so node 0 is in the MSBs.
- flush  in  1  synchronous clear of all pending entries.
- load_ready  out  1  high when the queue is empty.
- out_valid  out  1  an entry is presented on index_out/value_out.
- out_ready  in  1  downstream accepts the presented entry.
- index_out  out  IW  node index of the presented entry.
- value_out  out  VALUE_WIDTH  value of the presented entry.
- last_out  out  1  the presented entry is the only one pending.
- queue_empty  out  1  no entries pending.
- pending_count  out  CW  number of pending entries.

## Operation
- State:
  - value snapshot register, NODE_COUNT*VALUE_WIDTH bits;
  - pending mask, NODE_COUNT bits;
  - pending_count register.
- Load: when load=1, load_ready=1 and flush=0:
  - snapshot <= node_values_in;
  - mask[i] <= SKIP_ZERO ? (value_i != 0) : 1;
  - pending_count <= popcount of the new mask.
- A load while load_ready=0 is ignored. The snapshot and mask are unchanged and no error is flagged.
- Presentation (combinational from registers):
  - out_valid = |mask;
  - index_out = lowest set bit index of mask (fixed priority, index 0 first);
  - value_out = snapshot value at index_out.
- When out_valid=0, index_out and value_out are driven to 0.
- last_out = out_valid && (pending_count == 1).
- Transfer occurs when out_valid && out_ready. On a transfer, mask bit index_out clears and pending_count decrements.
- With out_ready=0, the presented outputs hold stable.
- queue_empty = ~|mask; load_ready = queue_empty.
- Flush: mask <= 0 and pending_count <= 0. The snapshot is left unchanged. A transfer in the same cycle is discarded.
- Precedence: reset_n > flush > load > transfer. Load and transfer cannot coincide because load_ready implies out_valid=0.
- All-zero snapshot with SKIP_ZERO=1: the mask stays 0, queue_empty stays 1, nothing is emitted.

## Timing
- Reset values:
  - load_ready=1, queue_empty=1;
  - out_valid=0, last_out=0;
  - index_out=0, value_out=0, pending_count=0;
  - snapshot and mask all 0.
- Load accepted at edge N: out_valid=1 from cycle N+1, and the first entry is presented in that cycle.
- Throughput is one entry per cycle with out_ready held high. A snapshot with k entries drains in k cycles after the load edge.
- queue_empty and load_ready rise in the cycle after the final transfer. The earliest next load edge is at the end of that cycle.
- Flush at edge N: out_valid=0 and load_ready=1 from cycle N+1.
- reset_n low mid-drain clears all outputs immediately, without waiting for a clock edge.

## Test plan
- Reset: hold reset_n=0 with random inputs, then release. Required: load_ready=1, queue_empty=1, out_valid=0, index_out=0, value_out=0, pending_count=0.
- Full drain, SKIP_ZERO=1: load 0x12345678 with out_ready=1.
  - Required: (index,value) = (0,1),(1,2),...,(7,8) on 8 consecutive cycles starting the cycle after load.
  - last_out=1 only on (7,8); queue_empty=1 the next cycle.
- Sparse plus back-pressure: load 0x0A0000B0, so node1=A and node6=B. Hold out_ready=0 for 3 cycles, then set it to 1.
  - Required: pending_count=2 and (1,A) held stable for 3 cycles.
  - Then (6,B) with last_out=1, then pending_count=0.
- Zero-skip modes: load 0x00000000 with SKIP_ZERO=1. Required: out_valid stays 0 and load_ready stays 1.
  - Same load with SKIP_ZERO=0. Required: 8 entries with value 0, indices 0..7.
- Busy load and flush: load 0x11111111, drain 2 entries, then pulse load with 0x22222222.
  - Required: the second load is ignored and entries (2,1) onward continue.
  - Then pulse flush together with out_ready=1. Required: out_valid=0 and pending_count=0 next cycle.
- Async reset mid-drain: drop reset_n between clock edges after 3 transfers. Required: out_valid=0 and queue_empty=1 before the next edge. After release, a fresh load drains correctly.
